// File: rtl/fdct_8x8_if.sv
// fdct_8x8_if: block-level bus of the forward 8x8 DCT.
//   en        : start request from the producer, sampled only while idle
//   pix       : 64 unsigned 8-bit pixels, pixel (i,j) at pix[(i*8+j)*8 +: 8]
//   coef      : 64 signed COEF_W-bit coefficients, (u,v) at coef[(u*8+v)*COEF_W +: COEF_W]
//   busy      : a block is in flight
//   done      : one-cycle completion pulse, coef is valid from this cycle on
//   dbg_state : FSM state of the DCT engine (0 idle, 1 pass 1, 2 pass 2, 3 output)
//
// Handshake: en acts as "valid" and !busy as "ready". A start is accepted at a
// rising edge where the engine is idle and en=1; pix is captured at that same
// edge and may change freely afterwards. en seen while busy is ignored. Exactly
// one done pulse follows each accepted start unless rst aborts the block.
interface fdct_8x8_if #(
  parameter int COEF_W = 11
);
  logic                   en;
  logic [511:0]           pix;
  logic [64*COEF_W-1:0]   coef;
  logic                   busy;
  logic                   done;
  logic [1:0]             dbg_state;

  modport master (
    output en, pix,
    input  coef, busy, done, dbg_state
  );

  modport slave (
    input  en, pix,
    output coef, busy, done, dbg_state
  );
endinterface

// File: rtl/fdct_8x8.sv
// fdct_8x8: forward 8x8 2-D DCT, Y = T*(X-128)*T' with T scaled by SCALE.
// A single multiply-accumulate is time-multiplexed over two 512-cycle passes:
// pass 1 forms A = T*S (column transform), pass 2 forms Y = A*T'.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset (aborts any block in flight)
//   bus : fdct_8x8_if.slave (en, pix in; coef, busy, done, dbg_state out)
module fdct_8x8 (
  input  logic        clk,
  input  logic        rst,
  fdct_8x8_if.slave   bus
);

  localparam int SCALE  = 10000;
  localparam int COEF_W = 11;

  // T[u][x] at index u*8+x
  localparam logic signed [15:0] T_TAB [64] = '{
     16'sd3536,  16'sd3536,  16'sd3536,  16'sd3536,  16'sd3536,  16'sd3536,  16'sd3536,  16'sd3536,
     16'sd4904,  16'sd4157,  16'sd2778,   16'sd975,  -16'sd975, -16'sd2778, -16'sd4157, -16'sd4904,
     16'sd4619,  16'sd1913, -16'sd1913, -16'sd4619, -16'sd4619, -16'sd1913,  16'sd1913,  16'sd4619,
     16'sd4157,  -16'sd975, -16'sd4904, -16'sd2778,  16'sd2778,  16'sd4904,   16'sd975, -16'sd4157,
     16'sd3536, -16'sd3536, -16'sd3536,  16'sd3536,  16'sd3536, -16'sd3536, -16'sd3536,  16'sd3536,
     16'sd2778, -16'sd4904,   16'sd975,  16'sd4157, -16'sd4157,  -16'sd975,  16'sd4904, -16'sd2778,
     16'sd1913, -16'sd4619,  16'sd4619, -16'sd1913, -16'sd1913,  16'sd4619, -16'sd4619,  16'sd1913,
      16'sd975, -16'sd2778,  16'sd4157, -16'sd4904,  16'sd4904, -16'sd4157,  16'sd2778,  -16'sd975
  };

  typedef enum logic [1:0] {IDLE = 2'd0, PASS1 = 2'd1, PASS2 = 2'd2, OUT = 2'd3} state_t;

  state_t state, state_next;

  logic signed [8:0]        s_mem [64];   // centred pixels s[i][j] at i*8+j
  logic signed [11:0]       a_mem [64];   // pass-1 result A[i][j]
  logic signed [COEF_W-1:0] y_mem [64];   // pass-2 result, copied to coef only in OUT

  // One counter walks (i,j,k) with k fastest, so its field split gives the indices.
  logic [8:0]  idx;
  logic [2:0]  ri, cj, kk;
  logic        last;

  logic signed [31:0]       acc, acc_sum, quot;
  logic signed [31:0]       mul_a, mul_b;
  logic signed [COEF_W-1:0] y_sat;
  logic [64*COEF_W-1:0]     coef_q;
  logic                     busy_q, done_q;

  assign ri   = idx[8:6];
  assign cj   = idx[5:3];
  assign kk   = idx[2:0];
  assign last = (idx == 9'd511);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.en) state_next = PASS1;
      PASS1:   if (last)   state_next = PASS2;
      PASS2:   if (last)   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // MAC operand selection: pass 1 uses T[i][k]*s[k][j], pass 2 uses A[i][k]*T[j][k].
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == PASS2) begin
      mul_a = 32'(a_mem[{ri, kk}]);
      mul_b = 32'(T_TAB[{cj, kk}]);
    end else begin
      mul_a = 32'(T_TAB[{ri, kk}]);
      mul_b = 32'(s_mem[{kk, cj}]);
    end
  end

  assign acc_sum = acc + mul_a * mul_b;
  // Signed '/' truncates toward zero, which is the rounding this block must produce.
  assign quot    = acc_sum / SCALE;

  // Only the final coefficients are clamped; A always fits in 12 bits.
  always_comb begin
    y_sat = quot[COEF_W-1:0];
    if (quot > 32'sd1023)       y_sat = 11'h3FF;
    else if (quot < -32'sd1024) y_sat = 11'h400;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 64; n++) begin
        s_mem[n] <= '0;
        a_mem[n] <= '0;
        y_mem[n] <= '0;
      end
      idx    <= '0;
      acc    <= '0;
      coef_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) begin
            for (int n = 0; n < 64; n++)
              s_mem[n] <= $signed({1'b0, bus.pix[n*8 +: 8]} - 9'd128);
            idx    <= '0;
            acc    <= '0;
            busy_q <= 1'b1;
          end
        end
        PASS1, PASS2: begin
          idx <= idx + 9'd1;
          if (kk == 3'd7) begin
            acc <= '0;
            if (state == PASS1) a_mem[{ri, cj}] <= quot[11:0];
            else                y_mem[{ri, cj}] <= y_sat;
          end else begin
            acc <= acc_sum;
          end
        end
        OUT: begin
          for (int n = 0; n < 64; n++)
            coef_q[n*COEF_W +: COEF_W] <= y_mem[n];
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.coef      = coef_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_fdct_8x8.sv
// tb_fdct_8x8: self-checking bench for fdct_8x8. Directed table of uniform and
// single-impulse blocks, randomized blocks against a matrix-product reference
// model, continuous-en back-to-back sequence, and a mid-block reset abort.
module tb_fdct_8x8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  fdct_8x8_if bus ();

  fdct_8x8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [703:0] exp_q[$];
  logic [703:0] last_exp = '0;

  int t_tab [8][8] = '{
    '{3536,  3536,  3536,  3536,  3536,  3536,  3536,  3536},
    '{4904,  4157,  2778,   975,  -975, -2778, -4157, -4904},
    '{4619,  1913, -1913, -4619, -4619, -1913,  1913,  4619},
    '{4157,  -975, -4904, -2778,  2778,  4904,   975, -4157},
    '{3536, -3536, -3536,  3536,  3536, -3536, -3536,  3536},
    '{2778, -4904,   975,  4157, -4157,  -975,  4904, -2778},
    '{1913, -4619,  4619, -1913, -1913,  4619, -4619,  1913},
    '{ 975, -2778,  4157, -4904,  4904, -4157,  2778,  -975}
  };

  // Reference: plain integer matrix products, '/' truncates toward zero.
  function automatic int model_a(input logic [511:0] p, input int u, input int j);
    int sum = 0;
    for (int x = 0; x < 8; x++)
      sum += t_tab[u][x] * (int'(p[(x*8+j)*8 +: 8]) - 128);
    return sum / 10000;
  endfunction

  function automatic logic [703:0] dct_model(input logic [511:0] p);
    int a [8][8];
    int sum, y;
    logic [703:0] r = '0;
    for (int u = 0; u < 8; u++)
      for (int j = 0; j < 8; j++)
        a[u][j] = model_a(p, u, j);
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        sum = 0;
        for (int x = 0; x < 8; x++) sum += a[u][x] * t_tab[v][x];
        y = sum / 10000;
        if (y > 1023)  y = 1023;
        if (y < -1024) y = -1024;
        r[(u*8+v)*11 +: 11] = y[10:0];
      end
    return r;
  endfunction

  function automatic int coef_at(input logic [703:0] c, input int u, input int v);
    logic signed [10:0] t;
    t = c[(u*8+v)*11 +: 11];
    return int'(t);
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [703:0] act, input logic [703:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      for (int n = 0; n < 64; n++)
        if (act[n*11 +: 11] !== exp[n*11 +: 11]) begin
          $display("FAIL %s: coef(%0d,%0d) got %0d, expected %0d", name, n/8, n%8,
                   coef_at(act, n/8, n%8), coef_at(exp, n/8, n%8));
          break;
        end
    end
  endtask

  task automatic check_sb(input string name);
    logic [703:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: done with empty expected queue", name);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check_vec(name, bus.coef, e);
    end
  endtask

  // Waits for done (sampled on negedges); lat counts rising edges waited.
  task automatic wait_done(output int lat);
    bit got = 0;
    lat = 0;
    for (int c = 0; c < 1100 && !got; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) got = 1;
    end
    if (!got) lat = -1;
  endtask

  task automatic run_block(input string name, input logic [511:0] p);
    int lat;
    bus.pix = p;
    bus.en  = 1'b1;
    exp_q.push_back(dct_model(p));
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    check_int({name, "_busy_start"}, int'(bus.busy), 1);
    wait_done(lat);
    check_int({name, "_latency"}, lat, 1025);
    check_int({name, "_busy_in_done"}, int'(bus.busy), 0);
    check_sb({name, "_coef"});
    @(negedge clk);
    check_int({name, "_done_width"}, int'(bus.done), 0);
  endtask

  function automatic logic [511:0] rand_block(input bit extremes);
    logic [511:0] p;
    for (int n = 0; n < 64; n++)
      p[n*8 +: 8] = extremes ? ($urandom_range(0, 1) ? 8'd255 : 8'd0) : 8'($urandom_range(0, 255));
    return p;
  endfunction

  typedef struct {
    string      name;
    logic [7:0] fill;
    logic [7:0] p00;
    int         e00, e01, e11;
    int         a_u, a_val;   // expected A[a_u][0]
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [511:0] p, p1, p2;
    int lat, t0, t1;
    bit got;

    vecs[0] = '{"mid",    8'd128, 8'd128,     0,  0,  0, 0,    0};
    vecs[1] = '{"black",  8'd0,   8'd0,   -1024,  0,  0, 0, -362};
    vecs[2] = '{"white",  8'd255, 8'd255,  1015,  0,  0, 0,  359};
    vecs[3] = '{"impulse",8'd128, 8'd228,    12, 17, 24, 1,   49};

    bus.en  = 1'b0;
    bus.pix = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_vec("reset_coef", bus.coef, '0);
    check_int("reset_busy", int'(bus.busy), 0);
    check_int("reset_done", int'(bus.done), 0);
    check_int("reset_state", int'(bus.dbg_state), 0);

    // Directed table
    foreach (vecs[t]) begin
      for (int n = 0; n < 64; n++) p[n*8 +: 8] = vecs[t].fill;
      p[7:0] = vecs[t].p00;
      run_block(vecs[t].name, p);
      check_int({vecs[t].name, "_c00"}, coef_at(bus.coef, 0, 0), vecs[t].e00);
      check_int({vecs[t].name, "_c01"}, coef_at(bus.coef, 0, 1), vecs[t].e01);
      check_int({vecs[t].name, "_c11"}, coef_at(bus.coef, 1, 1), vecs[t].e11);
      check_int({vecs[t].name, "_a"}, int'(dut.a_mem[vecs[t].a_u*8]), vecs[t].a_val);
    end
    check_int("impulse_a70", int'(dut.a_mem[56]), 9);

    // Randomized blocks
    for (int r = 0; r < 5; r++) begin
      p = rand_block(r == 4);
      run_block("rand", p);
      check_int("rand_a_model", int'(dut.a_mem[9]), model_a(p, 1, 1));
    end
    repeat (20) @(negedge clk);
    check_vec("coef_hold_idle", bus.coef, last_exp);

    // en held high; pix changes mid-block; back-to-back restart on the done edge
    p1 = rand_block(0);
    p2 = rand_block(0);
    bus.pix = p1;
    bus.en  = 1'b1;
    exp_q.push_back(dct_model(p1));
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    repeat (100) @(negedge clk);
    bus.pix = p2;
    exp_q.push_back(dct_model(p2));
    wait_done(lat);
    t1 = cyc;
    check_int("hold_first_latency", t1 - t0, 1025);
    check_sb("hold_first_coef");
    wait_done(lat);
    bus.en = 1'b0;
    check_int("hold_period", cyc - t1, 1026);
    check_sb("hold_second_coef");
    @(negedge clk);
    check_int("hold_done_width", int'(bus.done), 0);
    repeat (5) @(negedge clk);
    check_int("hold_idle_after", int'(bus.busy), 0);

    // Mid-block reset abort
    bus.pix = rand_block(0);
    bus.en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    repeat (600) @(negedge clk);
    check_vec("coef_hold_busy", bus.coef, last_exp);
    rst = 1'b1;
    #1;
    check_vec("abort_coef", bus.coef, '0);
    check_int("abort_busy", int'(bus.busy), 0);
    check_int("abort_done", int'(bus.done), 0);
    check_int("abort_state", int'(bus.dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    got = 0;
    repeat (1200) begin
      @(negedge clk);
      if (bus.done) got = 1;
    end
    check_int("abort_no_done", int'(got), 0);
    run_block("after_abort", rand_block(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fdct_8x8.md
Name: fdct_8x8

Overview:
- Forward 8x8 2-D DCT for the compression path; converts an 8x8 block of unsigned 8-bit pixels into 64 signed 11-bit coefficients.
- Its output format is exactly what the inverse-DCT block consumes, so the output can feed it directly.
- Computes Y = T·(X−128)·Tᵀ with fixed-point T scaled by 10000.
- Uses a single time-multiplexed multiply-accumulate, two passes of 512 cycles each.

Parameters:
- SCALE, 10000, fixed-point divisor of T entries; not intended to be changed.
- COEF_W, 11, coefficient width in bits; the output bus is 64*COEF_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; sampled only in IDLE.
- pix  in  512  pixel (i,j) at pix[(i*8+j)*8 +: 8], unsigned, i=row, j=column.
- coef  out  704  coefficient (u,v) at coef[(u*8+v)*11 +: 11], two's complement; u=vertical, v=horizontal frequency.
- busy  out  1  high while a block is in flight.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, coef=0, busy=0, done=0, internal arrays and counters cleared. An aborted block never produces done.
- T[u][x] (x=0..7), all signed:
  - u0: 3536 x8
  - u1: 4904 4157 2778 975 -975 -2778 -4157 -4904
  - u2: 4619 1913 -1913 -4619 -4619 -1913 1913 4619
  - u3: 4157 -975 -4904 -2778 2778 4904 975 -4157
  - u4: 3536 -3536 -3536 3536 3536 -3536 -3536 3536
  - u5: 2778 -4904 975 4157 -4157 -975 4904 -2778
  - u6: 1913 -4619 4619 -1913 -1913 4619 -4619 1913
  - u7: 975 -2778 4157 -4904 4904 -4157 2778 -975
- States:
  - IDLE: done=0. If en=1 at an edge, capture s[i][j]=pix(i,j)−128 as 9-bit signed, set busy=1, clear indices i,j,k, go to PASS1. If en=0, stay.
  - PASS1: one MAC per cycle. acc += T[i][k]*s[k][j], 32-bit signed accumulator.
    - When k=7, write A[i][j]=(acc incl. this term)/SCALE, truncated toward zero, held 12-bit signed; then clear acc.
    - Index order: k fastest, then j, then i. 512 cycles total.
    - After (7,7,7), go to PASS2.
  - PASS2: acc += A[i][k]*T[j][k]. When k=7, write Y[i][j]=acc/SCALE, truncated toward zero, then saturated to [−1024,1023]. 512 cycles, same index order. Then go to OUT.
  - OUT (1 cycle): load coef from Y in a single update; busy=0, done=1; go to IDLE.
- Latency: en sampled at edge E0.
  - PASS1 occupies edges E1..E512.
  - PASS2 occupies edges E513..E1024.
  - coef updates and done rises at E1025, and done falls at E1026.
  - busy is high from E0 through E1025 (exclusive).
  - Throughput: one block per 1026 cycles.
- en while busy is ignored; pix changes after E0 have no effect.
- en=1 during the done cycle (state is already IDLE) starts a new block at that edge; done still falls at that edge.
- coef holds the last result until the next OUT. It never shows partial values.
- Division by SCALE truncates toward zero, not floor. Negative sums must match this, e.g. −10240256/10000 = −1024.
- Saturation applies only to the final Y.

Test Plan:
- All pixels 128, en pulse → done 1025 cycles after the en edge; all 64 coef = 0; busy low again in the done cycle.
- All pixels 0 → coef(0,0) = −1024 (11'h400); all other coef = 0. Check that A[0][j] = −362.
- All pixels 255 → coef(0,0) = 1015; all other coef = 0. Check that A[0][j] = 359 (truncation of 359.26).
- pix(0,0) = 228, rest 128:
  - A[u][0] = 35,49,46,41,35,27,19,9.
  - coef(0,0) = 12, coef(1,1) = 24, coef(0,1) = trunc(35*4904/10000) = 17.
- en held high continuously plus pix changed mid-block → the first result matches the original pix; a second block starts on the done edge; done pulses every 1026 cycles.
- rst asserted at cycle ~600 of a block → coef = 0, busy = 0, no done pulse. A fresh en afterwards gives the correct result with full latency.
